// File: rtl/alu_acc_stream_if.sv
// alu_acc_stream_if: request/response bundle between the instruction
// sequencer (master) and the accumulator ALU (slave).
//   Request  : in_valid, in_ready, opcode[3:0], A, B
//   Response : out_valid, out_ready, ALU_Out, flag_z/c/v/err
//   State    : acc (architecturally visible accumulator)
interface alu_acc_stream_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_Out;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_err;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, opcode, A, B, out_ready,
        input  in_ready, out_valid, ALU_Out, flag_z, flag_c, flag_v, flag_err, acc
    );

    modport slave (
        input  in_valid, opcode, A, B, out_ready,
        output in_ready, out_valid, ALU_Out, flag_z, flag_c, flag_v, flag_err, acc
    );
endinterface

// File: rtl/alu_acc_stream.sv
// alu_acc_stream: WIDTH-generic opcode ALU with an architecturally visible
// accumulator, status flags, valid/ready handshakes on both sides and a
// multi-cycle restoring divider.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_acc_stream_if.slave: request (in_valid/in_ready/opcode/A/B),
//            response (out_valid/out_ready/ALU_Out/flags) and acc
// Non-DIV ops produce a result the cycle after accept; DIV takes WIDTH edges.
// A result may be popped and a new op accepted on the same edge.
module alu_acc_stream #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_acc_stream_if.slave   bus
);

    localparam int               CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST_C = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] W_C        = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_ADDA = 4'd4;
    localparam logic [3:0] OP_MULA = 4'd5;
    localparam logic [3:0] OP_MAC  = 4'd6;
    localparam logic [3:0] OP_ROL  = 4'd7;
    localparam logic [3:0] OP_ROR  = 4'd8;
    localparam logic [3:0] OP_LDA  = 4'd9;
    localparam logic [3:0] OP_CLRA = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             flag_z_r;
    logic             flag_c_r;
    logic             flag_v_r;
    logic             flag_err_r;
    logic [WIDTH-1:0] acc_r;

    // divider working registers
    logic [WIDTH-1:0] div_q_r;
    logic [WIDTH-1:0] div_rem_r;
    logic [WIDTH-1:0] div_b_r;
    logic             div_bz_r;
    logic [CW-1:0]    div_cnt_r;

    logic             in_ready_s;
    logic             accept_s;

    logic [WIDTH-1:0] res_s;
    logic             c_s;
    logic             v_s;
    logic             err_s;
    logic             acc_wr_s;
    logic [WIDTH-1:0] acc_nxt_s;

    logic [WIDTH:0]     sum_ab_s;
    logic [WIDTH:0]     diff_ab_s;
    logic [WIDTH:0]     sum_acc_a_s;
    logic [WIDTH:0]     sum_mac_s;
    logic [2*WIDTH-1:0] prod_ab_s;
    logic [2*WIDTH-1:0] prod_acc_a_s;
    logic [WIDTH-1:0]   sh_s;
    logic [2*WIDTH-1:0] rol_s;
    logic [2*WIDTH-1:0] ror_s;

    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   trial_s;
    logic [WIDTH-1:0] rem_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;

    // Ready when idle, or when the held result is being popped this edge.
    assign in_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.ALU_Out   = result_r;
    assign bus.flag_z    = flag_z_r;
    assign bus.flag_c    = flag_c_r;
    assign bus.flag_v    = flag_v_r;
    assign bus.flag_err  = flag_err_r;
    assign bus.acc       = acc_r;

    // Single-cycle datapath: result, flags and accumulator update for the presented op.
    always_comb begin
        res_s     = {WIDTH{1'b0}};
        c_s       = 1'b0;
        v_s       = 1'b0;
        err_s     = 1'b0;
        acc_wr_s  = 1'b0;
        acc_nxt_s = acc_r;

        sum_ab_s     = {1'b0, bus.A} + {1'b0, bus.B};
        diff_ab_s    = {1'b0, bus.A} - {1'b0, bus.B};
        prod_ab_s    = {{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B};
        prod_acc_a_s = {{WIDTH{1'b0}}, acc_r} * {{WIDTH{1'b0}}, bus.A};
        sum_acc_a_s  = {1'b0, acc_r} + {1'b0, bus.A};
        sum_mac_s    = {1'b0, acc_r} + {1'b0, prod_ab_s[WIDTH-1:0]};
        // rotate via a doubled word so any amount 0..WIDTH-1 is one shift
        sh_s         = bus.B % W_C;
        rol_s        = {bus.A, bus.A} << sh_s;
        ror_s        = {bus.A, bus.A} >> sh_s;

        case (bus.opcode)
            OP_ADD: begin
                res_s = sum_ab_s[WIDTH-1:0];
                c_s   = sum_ab_s[WIDTH];
                v_s   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (res_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                res_s = diff_ab_s[WIDTH-1:0];
                c_s   = diff_ab_s[WIDTH];
                v_s   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (res_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_MUL: begin
                res_s = prod_ab_s[WIDTH-1:0];
                c_s   = |prod_ab_s[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                res_s = {WIDTH{1'b0}};
            end
            OP_ADDA: begin
                res_s     = sum_acc_a_s[WIDTH-1:0];
                c_s       = sum_acc_a_s[WIDTH];
                acc_wr_s  = 1'b1;
                acc_nxt_s = sum_acc_a_s[WIDTH-1:0];
            end
            OP_MULA: begin
                res_s     = prod_acc_a_s[WIDTH-1:0];
                c_s       = |prod_acc_a_s[2*WIDTH-1:WIDTH];
                acc_wr_s  = 1'b1;
                acc_nxt_s = prod_acc_a_s[WIDTH-1:0];
            end
            OP_MAC: begin
                res_s     = sum_mac_s[WIDTH-1:0];
                c_s       = (|prod_ab_s[2*WIDTH-1:WIDTH]) || sum_mac_s[WIDTH];
                acc_wr_s  = 1'b1;
                acc_nxt_s = sum_mac_s[WIDTH-1:0];
            end
            OP_ROL: begin
                res_s = rol_s[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                res_s = ror_s[WIDTH-1:0];
            end
            OP_LDA: begin
                res_s     = bus.A;
                acc_wr_s  = 1'b1;
                acc_nxt_s = bus.A;
            end
            OP_CLRA: begin
                res_s     = ACC_INIT;
                acc_wr_s  = 1'b1;
                acc_nxt_s = ACC_INIT;
            end
            default: begin
                res_s = {WIDTH{1'b0}};
                err_s = 1'b1;
            end
        endcase
    end

    // One restoring-division step: shift in the next dividend bit, try to subtract.
    always_comb begin
        rem_sh_s = {div_rem_r, div_q_r[WIDTH-1]};
        trial_s  = rem_sh_s - {1'b0, div_b_r};
        // A zero divisor always "fits", which yields the all-ones quotient.
        if (!trial_s[WIDTH] || div_bz_r) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            q_nxt_s   = {div_q_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[WIDTH-1:0];
            q_nxt_s   = {div_q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM with registered result, flags, accumulator and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            flag_z_r    <= 1'b0;
            flag_c_r    <= 1'b0;
            flag_v_r    <= 1'b0;
            flag_err_r  <= 1'b0;
            acc_r       <= ACC_INIT;
            div_q_r     <= {WIDTH{1'b0}};
            div_rem_r   <= {WIDTH{1'b0}};
            div_b_r     <= {WIDTH{1'b0}};
            div_bz_r    <= 1'b0;
            div_cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            if (bus.opcode == OP_DIV) begin
                state_r     <= ST_DIV;
                out_valid_r <= 1'b0;
                div_q_r     <= bus.A;
                div_rem_r   <= {WIDTH{1'b0}};
                div_b_r     <= bus.B;
                div_bz_r    <= (bus.B == {WIDTH{1'b0}});
                div_cnt_r   <= {CW{1'b0}};
            end else begin
                state_r     <= ST_DONE;
                out_valid_r <= 1'b1;
                result_r    <= res_s;
                flag_z_r    <= (res_s == {WIDTH{1'b0}});
                flag_c_r    <= c_s;
                flag_v_r    <= v_s;
                flag_err_r  <= err_s;
                if (acc_wr_s) begin
                    acc_r <= acc_nxt_s;
                end
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_DIV: begin
                    div_q_r   <= q_nxt_s;
                    div_rem_r <= rem_nxt_s;
                    div_cnt_r <= div_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (div_cnt_r == CNT_LAST_C) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= q_nxt_s;
                        flag_z_r    <= (q_nxt_s == {WIDTH{1'b0}});
                        flag_c_r    <= 1'b0;
                        flag_v_r    <= 1'b0;
                        flag_err_r  <= div_bz_r;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_stream.sv
module tb_alu_acc_stream;

    localparam int W = 8;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flags; // {z, c, v, err}
        logic [7:0] acc;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_acc_stream_if #(.WIDTH(W)) bus ();

    alu_acc_stream #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    logic [7:0] model_acc = 8'h00;
    exp_t head;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference behaviour written from the opcode table with plain integers.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic [7:0] accv);
        exp_t e;
        int unsigned s, p, sh, ua, ub, uacc;
        int sa, sb, ss;
        logic c, v, err;
        ua = a; ub = b; uacc = accv;
        sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; err = 1'b0;
        e.acc = accv;
        e.res = 8'h00;
        case (op)
            4'd0: begin s = ua + ub; e.res = 8'(s); c = (s > 255); ss = sa + sb; v = (ss > 127) || (ss < -128); end
            4'd1: begin e.res = 8'(ua - ub); c = (ua < ub); ss = sa - sb; v = (ss > 127) || (ss < -128); end
            4'd2: begin p = ua * ub; e.res = 8'(p); c = (p > 255); end
            4'd3: begin
                if (ub == 0) begin e.res = 8'hFF; err = 1'b1; end
                else e.res = 8'(ua / ub);
            end
            4'd4: begin s = uacc + ua; e.res = 8'(s); c = (s > 255); e.acc = e.res; end
            4'd5: begin p = uacc * ua; e.res = 8'(p); c = (p > 255); e.acc = e.res; end
            4'd6: begin p = ua * ub; s = uacc + (p % 256); e.res = 8'(s); c = (p > 255) || (s > 255); e.acc = e.res; end
            4'd7: begin sh = ub % 8; e.res = 8'(((ua << sh) | (ua >> (8 - sh))) % 256); end
            4'd8: begin sh = ub % 8; e.res = 8'(((ua >> sh) | (ua << (8 - sh))) % 256); end
            4'd9: begin e.res = a; e.acc = a; end
            4'd10: begin e.res = 8'h00; e.acc = 8'h00; end
            default: begin e.res = 8'h00; err = 1'b1; end
        endcase
        e.flags = {(e.res == 8'h00), c, v, err};
        return e;
    endfunction

    // Monitor: compares every valid output cycle against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_acc = 8'h00;
        end else begin
            check("mon_spurious", {31'd0, (bus.out_valid && exp_q.size() == 0)}, 32'd0);
            if (bus.out_valid && exp_q.size() != 0) begin
                head = exp_q[0];
                check("mon_res",   {24'd0, bus.ALU_Out}, {24'd0, head.res});
                check("mon_flags", {28'd0, bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_err}, {28'd0, head.flags});
                check("mon_acc",   {24'd0, bus.acc}, {24'd0, head.acc});
                if (bus.out_ready) void'(exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                head = model(bus.opcode, bus.A, bus.B, model_acc);
                model_acc = head.acc;
                exp_q.push_back(head);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input string nm);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.A        = a;
        bus.B        = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
        end
        check({nm, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic run_single(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] er, input logic [3:0] ef, input logic [7:0] eacc,
                              input string nm);
        bus.out_ready = 1'b1;
        issue(op, a, b, nm);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check({nm, "_vld"},   {31'd0, bus.out_valid}, 32'd1);
        check({nm, "_res"},   {24'd0, bus.ALU_Out}, {24'd0, er});
        check({nm, "_flags"}, {28'd0, bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_err}, {28'd0, ef});
        check({nm, "_acc"},   {24'd0, bus.acc}, {24'd0, eacc});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.out_ready = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_alu_out",   {24'd0, bus.ALU_Out}, 32'd0);
        check("rst_flags",     {28'd0, bus.flag_z, bus.flag_c, bus.flag_v, bus.flag_err}, 32'd0);
        check("rst_acc",       {24'd0, bus.acc}, 32'd0);
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // flags order {z, c, v, err}
        run_single(4'd0, 8'h0A, 8'h05, 8'h0F, 4'b0000, 8'h00, "add_basic");
        run_single(4'd0, 8'hFF, 8'h01, 8'h00, 4'b1100, 8'h00, "add_carry");
        run_single(4'd0, 8'h7F, 8'h01, 8'h80, 4'b0010, 8'h00, "add_ovf");
        run_single(4'd1, 8'h00, 8'h01, 8'hFF, 4'b0100, 8'h00, "sub_borrow");
        run_single(4'd1, 8'h80, 8'h01, 8'h7F, 4'b0010, 8'h00, "sub_ovf");
        run_single(4'd1, 8'hFF, 8'hFF, 8'h00, 4'b1000, 8'h00, "sub_zero");
        run_single(4'd2, 8'h10, 8'h20, 8'h00, 4'b1100, 8'h00, "mul_hi");
        run_single(4'd7, 8'h81, 8'h01, 8'h03, 4'b0000, 8'h00, "rol");
        run_single(4'd8, 8'h01, 8'h09, 8'h80, 4'b0000, 8'h00, "ror");

        // DIV latency: out_valid low and in_ready low for WIDTH edges
        bus.out_ready = 1'b1;
        issue(4'd3, 8'h08, 8'h03, "div_lat");
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("div_busy_valid", {31'd0, bus.out_valid}, 32'd0);
            check("div_busy_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        check("div_done_valid", {31'd0, bus.out_valid}, 32'd1);
        check("div_done_res",   {24'd0, bus.ALU_Out}, 32'h02);
        @(posedge clk);
        #1;
        run_single(4'd3, 8'h08, 8'h00, 8'hFF, 4'b0001, 8'h00, "div_by_zero");

        // accumulator chain
        run_single(4'd9,  8'h02, 8'h00, 8'h02, 4'b0000, 8'h02, "lda");
        run_single(4'd4,  8'h0A, 8'h00, 8'h0C, 4'b0000, 8'h0C, "adda");
        run_single(4'd6,  8'h08, 8'h02, 8'h1C, 4'b0000, 8'h1C, "mac");
        run_single(4'd5,  8'h02, 8'h00, 8'h38, 4'b0000, 8'h38, "mula");
        run_single(4'd15, 8'h12, 8'h34, 8'h00, 4'b1001, 8'h38, "illegal");

        // back-to-back throughput
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.opcode   = 4'd0;
            bus.A        = 8'(i * 37 + 100);
            bus.B        = 8'(200 - i * 3);
            @(negedge clk);
            check("tp_ready", {31'd0, bus.in_ready}, 32'd1);
            if (i > 0) check("tp_valid", {31'd0, bus.out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("tp_last_valid", {31'd0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // backpressure: result held 3 cycles, pending op not lost
        bus.out_ready = 1'b0;
        issue(4'd0, 8'h03, 8'h04, "bp_first");
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd0;
        bus.A        = 8'h10;
        bus.B        = 8'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_res", {24'd0, bus.ALU_Out}, 32'h07);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_second_res",   {24'd0, bus.ALU_Out}, 32'h30);
        @(posedge clk);
        #1;

        // reset in the middle of a divide
        issue(4'd3, 8'hFF, 8'h03, "div_rst");
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_div_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_div_acc",   {24'd0, bus.acc}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_div_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_div_idle",  {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        run_single(4'd0, 8'h01, 8'h01, 8'h02, 4'b0000, 8'h00, "add_after_rst");

        // everything issued must have come out
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_acc_stream.md
Name: alu_acc_stream

Overview:
- Parametrised successor to the team's 8-bit opcode ALU.
- Keeps the same opcode map (ADD/SUB/MUL/DIV/ADDA/MULA/MAC/ROL/ROR) and adds LDA/CLRA, status flags and a WIDTH-generic datapath.
- Uses valid/ready handshakes on both input and output, and a multi-cycle restoring divider.
- Sits between the instruction sequencer and the result writeback stage; the accumulator is architecturally visible.

Parameters:
WIDTH, 8, operand/result/accumulator width in bits (>=4)
ACC_INIT, 0, accumulator value after reset and after CLRA

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept an operation this cycle
opcode  in  4  operation select
A  in  WIDTH  operand A
B  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  downstream accepts result
ALU_Out  out  WIDTH  result
flag_z  out  1  result == 0
flag_c  out  1  carry/borrow/high-half-nonzero
flag_v  out  1  signed overflow (ADD/SUB only)
flag_err  out  1  divide-by-zero or illegal opcode
acc  out  WIDTH  current accumulator

Behaviour:
- Single clock; reset is asynchronous, active-low.
- Reset values: state=IDLE, out_valid=0, ALU_Out=0, all flags 0, acc=ACC_INIT.
- Reset mid-operation (including mid-DIV) aborts the operation and loses it; nothing is committed.
- Handshake:
  - Accept occurs on an edge where in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Pop and accept on the same edge is legal: throughput is 1 op/cycle for non-DIV ops.
  - While out_valid=1 && out_ready=0, ALU_Out, flags and acc are held stable.
- FSM states:
  - IDLE: on accept of a non-DIV op, compute and register the result, go to DONE. On accept of DIV, go to DIV.
  - DIV: one restoring-division iteration per edge, WIDTH iterations. Commit on the last iteration, then go to DONE. in_ready=0 throughout.
  - DONE: out_valid=1. On out_ready with no new accept, go to IDLE. On out_ready with a new accept, behave as IDLE's accept.
- Latency:
  - Non-DIV ops: out_valid is high the cycle after the accept edge.
  - DIV: out_valid is high after the WIDTH-th edge following the accept edge.
- Operations (results are truncated to WIDTH unless stated):
  - 0 ADD: A+B. c=carry out, v=signed overflow.
  - 1 SUB: A-B. c=borrow (A<B unsigned), v=signed overflow.
  - 2 MUL: low half of A*B. c=1 if the high half is nonzero.
  - 3 DIV: A/B unsigned. If B==0: result all-ones, err=1, and the divider still takes WIDTH cycles.
  - 4 ADDA: acc+A, written to acc. c=carry.
  - 5 MULA: low half of acc*A, written to acc. c as MUL.
  - 6 MAC: acc + low half of A*B, written to acc. c=1 if the full-width product or the addition overflows.
  - 7 ROL: rotate A left by (B mod WIDTH).
  - 8 ROR: rotate A right by (B mod WIDTH).
  - 9 LDA: acc<=A, result=A.
  - 10 CLRA: acc<=ACC_INIT, result=ACC_INIT.
  - 11-15 illegal: result 0, err=1, acc unchanged.
- Flags: flag_z is computed on the result for every op. c and v are 0 where not defined above.
- Accumulator:
  - Operand acc is sampled at the accept edge.
  - acc is written at the same edge that registers the result.
  - The acc port reflects the updated value while out_valid is high.
- In-flight inputs: A, B and opcode are latched at accept; changes while busy have no effect.

Test Plan:
- WIDTH=8. ADD 0x0A+0x05 -> 0x0F, z=0 c=0. ADD 0xFF+0x01 -> 0x00, z=1 c=1. ADD 0x7F+0x01 -> 0x80, v=1.
- SUB 0x00-0x01 -> 0xFF, c=1 v=0. SUB 0x80-0x01 -> 0x7F, v=1. SUB 0xFF-0xFF -> 0x00, z=1.
- DIV 0x08/0x03 -> 0x02, out_valid first high after 8th edge post-accept, in_ready=0 throughout. DIV 0x08/0x00 -> 0xFF, err=1.
- Accumulator chain, out_ready=1: LDA 0x02; ADDA A=0x0A -> 0x0C; MAC A=0x08,B=0x02 -> 0x1C; MULA A=0x02 -> 0x38; acc=0x38. Then opcode 0xF -> 0x00, err=1, acc still 0x38.
- Backpressure/throughput:
  - Back-to-back ADDs with out_ready=1 give one result per cycle.
  - Hold out_ready=0 for 3 cycles: ALU_Out/flags/acc stable, in_ready=0, no op lost.
  - ROL 0x81 by 1 -> 0x03. ROR 0x01 by 9 -> 0x80.
- Reset mid-DIV: start DIV 0xFF/0x03, drop rst_n at 4th iteration edge -> out_valid=0, acc=ACC_INIT, in_ready=1 after release. A following ADD 1+1 -> 0x02 correct.
